// File: rtl/power_window_ctrl.sv
// Run sequencer for the cpu power-modeling harness: holds cpu reset, times a warm-up and a
// measurement window, and accumulates debug-bus toggle activity inside that window.
module power_window_ctrl #(
    parameter int unsigned      DBG_W         = 16,
    parameter int unsigned      CNT_W         = 32,
    parameter int unsigned      RST_CYCLES    = 2,
    parameter int unsigned      WARMUP_CYCLES = 4,
    parameter int unsigned      WINDOW_CYCLES = 10,
    parameter bit               MATCH_EN      = 1'b0,
    parameter logic [DBG_W-1:0] MATCH_VAL     = {DBG_W{1'b0}}
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             abort,
    input  logic [DBG_W-1:0] debug_in,
    output logic             cpu_rst,
    output logic             win_active,
    output logic             done,
    output logic             match_hit,
    output logic [CNT_W-1:0] toggle_count,
    output logic [CNT_W-1:0] cycle_count
);

    localparam int unsigned PC_W   = $clog2(DBG_W + 1);
    localparam int unsigned EXT_W  = (CNT_W > PC_W) ? CNT_W : PC_W;
    localparam int unsigned SUM_W  = EXT_W + 1;
    localparam int unsigned PH_MAX0 = (RST_CYCLES > WARMUP_CYCLES) ? RST_CYCLES : WARMUP_CYCLES;
    localparam int unsigned PH_MAX = (PH_MAX0 > WINDOW_CYCLES) ? PH_MAX0 : WINDOW_CYCLES;
    localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

    localparam logic [PH_W-1:0]  RST_LAST = PH_W'(RST_CYCLES - 1);
    localparam logic [PH_W-1:0]  WUP_LAST = PH_W'(WARMUP_CYCLES - 1);
    localparam logic [PH_W-1:0]  WIN_LAST = PH_W'(WINDOW_CYCLES - 1);
    localparam logic [SUM_W-1:0] CNT_MAX  = SUM_W'({CNT_W{1'b1}});

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_RESET   = 3'd1,
        S_WARMUP  = 3'd2,
        S_MEASURE = 3'd3,
        S_DONE    = 3'd4
    } state_e;

    function automatic logic [PC_W-1:0] popcount(input logic [DBG_W-1:0] v);
        logic [PC_W-1:0] n;
        n = {PC_W{1'b0}};
        for (int i = 0; i < DBG_W; i++) begin
            n = n + PC_W'(v[i]);
        end
        return n;
    endfunction

    // The sum is one bit wider than either operand, so it never wraps before the clamp.
    function automatic logic [CNT_W-1:0] sat_add(input logic [CNT_W-1:0] acc,
                                                 input logic [SUM_W-1:0] inc);
        logic [SUM_W-1:0] sum;
        logic [CNT_W-1:0] res;
        sum = SUM_W'(acc) + inc;
        if (sum > CNT_MAX) begin
            res = {CNT_W{1'b1}};
        end else begin
            res = sum[CNT_W-1:0];
        end
        return res;
    endfunction

    state_e           state_q, state_d;
    logic [PH_W-1:0]  ph_q, ph_d;
    logic [DBG_W-1:0] debug_q;
    logic             cpu_rst_q, cpu_rst_d;
    logic             win_q, win_d;
    logic             done_q, done_d;
    logic             hit_q, hit_d;
    logic [CNT_W-1:0] tc_q, tc_d;
    logic [CNT_W-1:0] cc_q, cc_d;
    logic             match_s;
    logic             run_req_s;
    logic [SUM_W-1:0] pop_s;

    assign match_s   = MATCH_EN && (debug_in == MATCH_VAL);
    assign run_req_s = start && ((state_q == S_IDLE) || (state_q == S_DONE));
    assign pop_s     = SUM_W'(popcount(debug_in ^ debug_q));

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            ph_q    <= {PH_W{1'b0}};
        end else begin
            state_q <= state_d;
            ph_q    <= ph_d;
        end
    end

    // ph_q counts cycles spent in the current timed state and restarts on every transition.
    always_comb begin
        state_d = state_q;
        ph_d    = ph_q;
        if (abort) begin
            state_d = S_IDLE;
            ph_d    = {PH_W{1'b0}};
        end else begin
            case (state_q)
                S_IDLE, S_DONE: begin
                    if (start) begin
                        state_d = S_RESET;
                        ph_d    = {PH_W{1'b0}};
                    end else begin
                        state_d = state_q;
                    end
                end
                S_RESET: begin
                    if (ph_q == RST_LAST) begin
                        state_d = S_WARMUP;
                        ph_d    = {PH_W{1'b0}};
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_WARMUP: begin
                    if (ph_q == WUP_LAST) begin
                        state_d = S_MEASURE;
                        ph_d    = {PH_W{1'b0}};
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                S_MEASURE: begin
                    if (match_s || (ph_q == WIN_LAST)) begin
                        state_d = S_DONE;
                        ph_d    = {PH_W{1'b0}};
                    end else begin
                        ph_d = ph_q + PH_W'(1);
                    end
                end
                default: begin
                    state_d = S_IDLE;
                    ph_d    = {PH_W{1'b0}};
                end
            endcase
        end
    end

    // Outputs decode the next state so the registered versions line up with the state itself.
    always_comb begin
        cpu_rst_d = 1'b1;
        win_d     = 1'b0;
        done_d    = 1'b0;
        case (state_d)
            S_WARMUP:  cpu_rst_d = 1'b0;
            S_MEASURE: begin
                cpu_rst_d = 1'b0;
                win_d     = 1'b1;
            end
            S_DONE:    done_d = 1'b1;
            default:   cpu_rst_d = 1'b1;
        endcase
    end

    // Counters: cleared on entry to RESET, accumulated in MEASURE, held otherwise (abort included).
    always_comb begin
        tc_d  = tc_q;
        cc_d  = cc_q;
        hit_d = hit_q;
        if (abort) begin
            tc_d = tc_q;
        end else if (state_q == S_MEASURE) begin
            tc_d = sat_add(tc_q, pop_s);
            cc_d = sat_add(cc_q, SUM_W'(1));
            if (match_s) begin
                hit_d = 1'b1;
            end else begin
                hit_d = hit_q;
            end
        end else if (run_req_s) begin
            tc_d  = {CNT_W{1'b0}};
            cc_d  = {CNT_W{1'b0}};
            hit_d = 1'b0;
        end else begin
            tc_d = tc_q;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            cpu_rst_q <= 1'b1;
            win_q     <= 1'b0;
            done_q    <= 1'b0;
            hit_q     <= 1'b0;
            tc_q      <= {CNT_W{1'b0}};
            cc_q      <= {CNT_W{1'b0}};
            debug_q   <= {DBG_W{1'b0}};
        end else begin
            cpu_rst_q <= cpu_rst_d;
            win_q     <= win_d;
            done_q    <= done_d;
            hit_q     <= hit_d;
            tc_q      <= tc_d;
            cc_q      <= cc_d;
            debug_q   <= debug_in;
        end
    end

    assign cpu_rst      = cpu_rst_q;
    assign win_active   = win_q;
    assign done         = done_q;
    assign match_hit    = hit_q;
    assign toggle_count = tc_q;
    assign cycle_count  = cc_q;

endmodule

// File: tb/tb_power_window_ctrl.sv
// Directed bench for power_window_ctrl: a default instance, an early-stop instance
// (MATCH_VAL=7) and a narrow-counter instance (CNT_W=4) share one stimulus stream.
module tb_power_window_ctrl;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start = 1'b0;
    logic        abort = 1'b0;
    logic [15:0] debug_in = 16'h0000;

    logic        a_cpu_rst, a_win, a_done, a_match;
    logic [31:0] a_tc, a_cc;
    logic        b_cpu_rst, b_win, b_done, b_match;
    logic [31:0] b_tc, b_cc;
    logic        c_cpu_rst, c_win, c_done, c_match;
    logic [3:0]  c_tc, c_cc;

    int total = 0;
    int bad   = 0;
    int k     = 0;
    int mode  = 0;

    always #5 clk = ~clk;

    power_window_ctrl u_a (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .debug_in(debug_in),
        .cpu_rst(a_cpu_rst), .win_active(a_win), .done(a_done), .match_hit(a_match),
        .toggle_count(a_tc), .cycle_count(a_cc)
    );

    power_window_ctrl #(.MATCH_EN(1'b1), .MATCH_VAL(16'h0007)) u_b (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .debug_in(debug_in),
        .cpu_rst(b_cpu_rst), .win_active(b_win), .done(b_done), .match_hit(b_match),
        .toggle_count(b_tc), .cycle_count(b_cc)
    );

    power_window_ctrl #(.CNT_W(4)) u_c (
        .clk(clk), .rst(rst), .start(start), .abort(abort), .debug_in(debug_in),
        .cpu_rst(c_cpu_rst), .win_active(c_win), .done(c_done), .match_hit(c_match),
        .toggle_count(c_tc), .cycle_count(c_cc)
    );

    typedef struct {
        int          mode;     // 0: counter, 1: constant A5A5, 2: alternating 0000/FFFF
        logic [31:0] a_tc;
        logic [31:0] b_tc;
        logic [31:0] b_cc;
        logic        b_match;
        int          b_last;   // last cycle index with b_win high
        logic [31:0] c_tc;
    } vec_t;

    vec_t tbl [3];

    function automatic logic [15:0] dbg_val(input int m, input int kk);
        logic [15:0] v;
        case (m)
            0:       v = 16'(kk);
            1:       v = 16'hA5A5;
            default: v = kk[0] ? 16'hFFFF : 16'h0000;
        endcase
        return v;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s k=%0d actual=%0h required=%0h", name, k, act, exp);
        end
    endtask

    // Advance one clock; k indexes the cycle following edge E_k after the start edge E_0.
    task automatic tick();
        @(posedge clk);
        #1;
        k++;
        debug_in = dbg_val(mode, k);
    endtask

    task automatic begin_run(input int m);
        mode     = m;
        k        = -1;
        debug_in = dbg_val(m, -1);
        start    = 1'b1;
        tick();
        start    = 1'b0;
    endtask

    initial begin
        tbl[0] = '{mode: 0, a_tc: 32'd18,  b_tc: 32'd3,   b_cc: 32'd2,  b_match: 1'b1, b_last: 7,  c_tc: 32'd15};
        tbl[1] = '{mode: 1, a_tc: 32'd0,   b_tc: 32'd0,   b_cc: 32'd10, b_match: 1'b0, b_last: 15, c_tc: 32'd0};
        tbl[2] = '{mode: 2, a_tc: 32'd160, b_tc: 32'd160, b_cc: 32'd10, b_match: 1'b0, b_last: 15, c_tc: 32'd15};

        repeat (2) @(posedge clk);
        #1;
        rst = 1'b0;
        chk("rst_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("rst_win",     32'(a_win),     32'd0);
        chk("rst_done",    32'(a_done),    32'd0);
        chk("rst_match",   32'(a_match),   32'd0);
        chk("rst_tc",      a_tc,           32'd0);
        chk("rst_cc",      a_cc,           32'd0);

        for (int r = 0; r < 3; r++) begin
            begin_run(tbl[r].mode);
            chk("start_clr_a_tc",  a_tc,            32'd0);
            chk("start_clr_b_hit", 32'(b_match),    32'd0);
            chk("start_clr_c_tc",  {28'd0, c_tc},   32'd0);
            for (int s = 0; s < 17; s++) begin
                chk("a_cpu_rst", 32'(a_cpu_rst), 32'(!(k >= 2 && k <= 15)));
                chk("a_win",     32'(a_win),     32'(k >= 6 && k <= 15));
                chk("a_done",    32'(a_done),    32'(k >= 16));
                chk("b_win",     32'(b_win),     32'(k >= 6 && k <= tbl[r].b_last));
                chk("b_done",    32'(b_done),    32'(k > tbl[r].b_last));
                tick();
            end
            chk("a_tc",    a_tc,            tbl[r].a_tc);
            chk("a_cc",    a_cc,            32'd10);
            chk("a_match", 32'(a_match),    32'd0);
            chk("b_tc",    b_tc,            tbl[r].b_tc);
            chk("b_cc",    b_cc,            tbl[r].b_cc);
            chk("b_match", 32'(b_match),    32'(tbl[r].b_match));
            chk("c_tc",    {28'd0, c_tc},   tbl[r].c_tc);
            chk("c_cc",    {28'd0, c_cc},   32'd10);
        end

        // start in WARMUP is ignored, then rst on the third MEASURE cycle
        begin_run(0);
        repeat (3) tick();
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("warm_start_cpu_rst", 32'(a_cpu_rst), 32'd0);
        tick();
        tick();
        chk("warm_start_win", 32'(a_win), 32'd1);
        tick();
        tick();
        chk("mid_cc", a_cc, 32'd2);
        chk("mid_tc", a_tc, 32'd3);
        rst = 1'b1;
        tick();
        rst = 1'b0;
        chk("rst_mid_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("rst_mid_win",     32'(a_win),     32'd0);
        chk("rst_mid_done",    32'(a_done),    32'd0);
        chk("rst_mid_tc",      a_tc,           32'd0);
        chk("rst_mid_cc",      a_cc,           32'd0);
        chk("rst_mid_b_hit",   32'(b_match),   32'd0);

        // abort mid-window (a) and in DONE (b) holds counts
        begin_run(0);
        repeat (8) tick();
        chk("pre_abort_b_done", 32'(b_done), 32'd1);
        abort = 1'b1;
        tick();
        abort = 1'b0;
        chk("abort_a_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("abort_a_win",     32'(a_win),     32'd0);
        chk("abort_a_tc",      a_tc,           32'd3);
        chk("abort_a_cc",      a_cc,           32'd2);
        chk("abort_b_done",    32'(b_done),    32'd0);
        chk("abort_b_tc",      b_tc,           32'd3);
        chk("abort_b_hit",     32'(b_match),   32'd1);

        // abort beats start in IDLE: no restart, counts untouched
        start = 1'b1;
        abort = 1'b1;
        tick();
        start = 1'b0;
        abort = 1'b0;
        chk("abort_start_tc", a_tc, 32'd3);
        repeat (3) tick();
        chk("abort_start_cpu_rst", 32'(a_cpu_rst), 32'd1);
        chk("abort_start_win",     32'(a_win),     32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
